accum_arbiter: RTL
==================

Name: accum_arbiter

Overview:
- Shares one 16-bit running-sum accumulator datapath between NREQ requesters.
- Each requester asks for a burst of `len` samples and streams them in under a valid/ready handshake.
- The block sums the burst and returns the result, tagged with the requester id, over a valid/ready output handshake.
- Arbitration is round-robin. The block sits between sample producers and downstream consumers of the sums.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, sample and sum width
- LENW, 8, burst-length field width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- req  input  NREQ  per-requester burst request, level
- len  input  NREQ*LENW  per-requester burst length; requester i uses bits [i*LENW +: LENW]
- in_data  input  NREQ*W  per-requester sample; requester i uses bits [i*W +: W]
- in_valid  input  NREQ  per-requester sample valid
- in_ready  output  NREQ  sample accept; at most one bit high, and only for the granted requester
- gnt  output  NREQ  one-hot grant, held for the whole burst including the result phase
- out_sum  output  W  burst sum
- out_id  output  $clog2(NREQ)  index of the requester that owns out_sum
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (reset=0): state=IDLE, gnt=0, in_ready=0, out_valid=0, out_sum=0, out_id=0, busy=0, accumulator=0, count=0, rr pointer=0.
- Reset is asynchronous and takes effect mid-burst: the partial sum is discarded and no result is emitted.
- State IDLE:
  - If any req bit is high, pick the first set bit searching from the rr pointer upward with wrap.
  - On the next edge: set gnt one-hot, latch id, latch len[id] into lreg, clear accumulator and count.
  - Go to ACCUM if lreg != 0, otherwise go to DONE.
  - Grant latency is one cycle from req being sampled high in IDLE.
- State ACCUM:
  - in_ready[id]=1; all other in_ready bits are 0.
  - A transfer occurs when in_valid[id] & in_ready[id] on a clock edge. On each transfer: acc <= acc + in_data[id], count <= count + 1.
  - When a transfer occurs with count == lreg-1, go to DONE. The sum must include that last sample.
  - Cycles with in_valid low are stalls: no change to acc or count, no timeout.
  - in_valid and in_data from non-granted requesters are ignored.
- State DONE:
  - out_valid=1, out_sum=acc, out_id=id. These are registered and stable while out_valid is high.
  - in_ready=0 and gnt is still held.
  - When out_valid & out_ready on an edge: set rr pointer=(id+1) mod NREQ, clear gnt, go to IDLE.
  - out_valid may stay high indefinitely; backpressure is unlimited.
- Arithmetic: unsigned. The default is modulo 2^W wrap, e.g. 0xFFFF + 0x0002 = 0x0001.
- len=0: no samples are taken, the result is 0, and it is reported in DONE one cycle after the grant.
- len is sampled only in IDLE. Changes to len during a burst have no effect.
- Deasserting req during a burst does not abort the burst; the burst completes with lreg samples.
- A requester whose req is still high after its result is accepted is served again only after every other active requester ahead of it in round-robin order has been served.
- Minimum burst cost: 1 arbitration cycle + lreg transfer cycles + 1 or more DONE cycles. There is no back-to-back grant in the cycle out_valid is accepted.

Optional Feature:
- Macro: ACCUM_ARBITER_SAT_EN.
- Defined:
  - Additions saturate at 2^W-1 (0xFFFF) instead of wrapping.
  - A sticky per-burst overflow bit is added and output on port `out_ovf` (1 bit). It is valid alongside out_valid and cleared when a new grant is issued.
- Undefined: modulo wrap, and the `out_ovf` port does not exist.

Test Plan:
- Single requester: req[0]=1, len=3, samples 0x0010, 0x0020, 0x0030 with no stalls -> gnt=0001 one cycle after req; out_sum=0x0060, out_id=0, out_valid high one cycle after the 3rd transfer.
- Stalls and backpressure: req[2], len=2, in_valid low for 3 cycles between the two samples 5 and 7; out_ready low for 4 cycles -> out_sum=12 held stable until out_ready=1; count is unaffected by the stalls.
- Round-robin: req=1111 held, each len=1, sample value=id+1 -> results in id order 0,1,2,3,0 with sums 1,2,3,4,1; in_ready is never high for a non-granted requester.
- Wrap/saturation: len=2, samples 0xFFFF and 0x0002 -> out_sum=0x0001 without the macro; out_sum=0xFFFF and out_ovf=1 with ACCUM_ARBITER_SAT_EN.
- len=0: req[1]=1, len=0 -> DONE reached one cycle after the grant with out_sum=0 and no in_ready pulse.
- Async reset: assert reset=0 between two edges midway through a len=4 burst, after 2 samples -> all outputs are 0 immediately; after release with req still high, a fresh grant to the lowest active requester (rr pointer=0) and a full 4-sample burst.

Source files
------------

// File: rtl/accum_arbiter_if.sv
// Bundle of request, sample and result handshakes for accum_arbiter.
// out_ovf exists only when ACCUM_ARBITER_SAT_EN is defined.
interface accum_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int LENW = 8
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]      req;
   logic [NREQ*LENW-1:0] len;
   logic [NREQ*W-1:0]    in_data;
   logic [NREQ-1:0]      in_valid;
   logic [NREQ-1:0]      in_ready;
   logic [NREQ-1:0]      gnt;
   logic [W-1:0]         out_sum;
   logic [IDW-1:0]       out_id;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;
`ifdef ACCUM_ARBITER_SAT_EN
   logic                 out_ovf;
`endif

   modport master (
      output req, len, in_data, in_valid, out_ready,
      input  in_ready, gnt, out_sum, out_id, out_valid, busy
`ifdef ACCUM_ARBITER_SAT_EN
      , input out_ovf
`endif
   );

   modport slave (
      input  req, len, in_data, in_valid, out_ready,
      output in_ready, gnt, out_sum, out_id, out_valid, busy
`ifdef ACCUM_ARBITER_SAT_EN
      , output out_ovf
`endif
   );
endinterface

// File: rtl/accum_arbiter.sv
// Round-robin shared burst accumulator: one requester at a time streams len samples, sum returned with its id.
// Define ACCUM_ARBITER_SAT_EN for saturating adds and a sticky out_ovf flag; default wraps modulo 2^W.
module accum_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int LENW = 8
) (
   input logic           clk,
   input logic           reset,
   accum_arbiter_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [NREQ-1:0] gnt_r;
   logic [IDW-1:0]  id_r;
   logic [IDW-1:0]  rr;
   logic [IDW-1:0]  pick;
   logic            found;
   logic [LENW-1:0] lreg;
   logic [LENW-1:0] count;
   logic [W-1:0]    acc;
   logic            xfer;
   logic            last;
   logic            busy_c;
   logic            out_valid_c;
`ifdef ACCUM_ARBITER_SAT_EN
   logic            ovf;
`endif

   logic [LENW-1:0] len_a  [NREQ];
   logic [W-1:0]    data_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign len_a[i]  = bus.len[i*LENW +: LENW];
      assign data_a[i] = bus.in_data[i*W +: W];
   end

   function automatic logic [W-1:0] accum_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ACCUM_ARBITER_SAT_EN
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[W] ? {W{1'b1}} : s[W-1:0];
`else
      return a + b;
`endif
   endfunction

`ifdef ACCUM_ARBITER_SAT_EN
   function automatic logic add_carry(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[W];
   endfunction
`endif

   // First requesting index at or above the rr pointer, wrapping around.
   always_comb begin
      logic [IDW-1:0] cand;
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(rr) + k) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign xfer = (state == ACCUM) && bus.in_valid[id_r];
   assign last = xfer && (count == lreg - 1'b1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy_c      = 1'b1;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (found) state_nxt = (len_a[pick] == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst context is captured at grant time; len changes mid-burst are not seen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_r <= '0;
         id_r  <= '0;
         rr    <= '0;
         lreg  <= '0;
         count <= '0;
         acc   <= '0;
`ifdef ACCUM_ARBITER_SAT_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  gnt_r <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  id_r  <= pick;
                  lreg  <= len_a[pick];
                  count <= '0;
                  acc   <= '0;
`ifdef ACCUM_ARBITER_SAT_EN
                  ovf   <= 1'b0;
`endif
               end
            end
            ACCUM: begin
               if (xfer) begin
                  acc   <= accum_add(acc, data_a[id_r]);
                  count <= count + 1'b1;
`ifdef ACCUM_ARBITER_SAT_EN
                  ovf   <= ovf | add_carry(acc, data_a[id_r]);
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  rr    <= (id_r == IDW'(NREQ-1)) ? '0 : id_r + 1'b1;
                  gnt_r <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // gnt_r is one-hot on id_r, so it doubles as the in_ready mask while accumulating.
   assign bus.in_ready  = (state == ACCUM) ? gnt_r : '0;
   assign bus.gnt       = gnt_r;
   assign bus.out_sum   = acc;
   assign bus.out_id    = id_r;
   assign bus.out_valid = out_valid_c;
   assign bus.busy      = busy_c;
`ifdef ACCUM_ARBITER_SAT_EN
   assign bus.out_ovf   = ovf;
`endif
endmodule
